// File: rtl/sine_sweep_pkg.sv
// sine_sweep_pkg: sweep FSM state encoding and default widths.
// Shared by sine_sweep_ctrl and sweep_dwell_timer.
package sine_sweep_pkg;

    localparam int FW_DEF = 8;
    localparam int DW_DEF = 24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DWELL,
        S_DONE
    } sweep_state_t;

endpackage

// File: rtl/sweep_dwell_timer.sv
// sweep_dwell_timer: counts 0..limit while enabled, tc on the last count.
// The counter wraps to 0 on tc so each code is held exactly limit+1 cycles.
module sweep_dwell_timer
    import sine_sweep_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [DW-1:0] i_limit,
    output logic          o_tc
);

    logic [DW-1:0] cnt;

    assign o_tc = i_en && (cnt == i_limit);

    // dwell counter: clear has priority, wrap on terminal count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (o_tc) begin
            cnt <= '0;
        end else if (i_en) begin
            cnt <= cnt + DW'(1);
        end
    end

endmodule

// File: rtl/sine_sweep_ctrl.sv
// sine_sweep_ctrl: steps a sine frequency code from start to stop.
// Define SINE_SWEEP_CONT_EN to enable the continuous triangle mode.
module sine_sweep_ctrl
    import sine_sweep_pkg::*;
#(
    parameter int            FW    = FW_DEF,
    parameter int            DW    = DW_DEF,
    parameter logic [FW-1:0] F_RST = 8'd50
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [FW-1:0] i_f_start,
    input  logic [FW-1:0] i_f_stop,
    input  logic [FW-1:0] i_f_step,
    input  logic [DW-1:0] i_dwell,
    input  logic          i_mode,
    output logic [FW-1:0] o_sine_f,
    output logic          o_f_valid,
    output logic          o_busy,
    output logic          o_done
);

    sweep_state_t  state;
    sweep_state_t  state_d;
    logic [FW-1:0] cur;
    logic [FW-1:0] sh_stop;
    logic [FW-1:0] sh_step;
    logic [DW-1:0] sh_dwell;
    logic          sh_up;
    logic          sh_mode;
    logic          valid_q;
    logic          load;
    logic          adv;
    logic          swap;
    logic          clr;
    logic          en;
    logic          tc;
    logic          up_eff;
    logic [FW-1:0] lim;
    logic [FW-1:0] nxt;

    // One step toward lim, clamped so it never passes lim or wraps.
    function automatic logic [FW-1:0] step_code(
        input logic [FW-1:0] c,
        input logic [FW-1:0] s,
        input logic [FW-1:0] l,
        input logic          up
    );
        logic [FW:0] t;
        if (up) begin
            t = {1'b0, c} + {1'b0, s};
            return (t > {1'b0, l}) ? l : t[FW-1:0];
        end
        t = {1'b0, c} - {1'b0, s};
        return (t[FW] || (t[FW-1:0] < l)) ? l : t[FW-1:0];
    endfunction

    sweep_dwell_timer #(
        .DW(DW)
    ) u_dwell (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clr  (clr),
        .i_en   (en),
        .i_limit(sh_dwell),
        .o_tc   (tc)
    );

    assign up_eff    = swap ? ~sh_up : sh_up;
    assign nxt       = step_code(cur, sh_step, lim, up_eff);
    assign o_sine_f  = cur;
    assign o_f_valid = valid_q;
    assign o_busy    = (state == S_DWELL);
    assign o_done    = (state == S_DONE);

`ifdef SINE_SWEEP_CONT_EN
    logic [FW-1:0] sh_start;

    // far end of the sweep, swapped with the stop code at each bounce
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh_start <= '0;
            sh_mode  <= 1'b0;
        end else if (load) begin
            sh_start <= i_f_start;
            sh_mode  <= i_mode;
        end else if (swap) begin
            sh_start <= sh_stop;
        end
    end

    assign lim = swap ? sh_start : sh_stop;
`else
    logic unused_mode;

    assign unused_mode = i_mode;
    assign sh_mode     = 1'b0;
    assign lim         = sh_stop;
`endif

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // next state and datapath strobes; abort beats start and dwell end
    always_comb begin
        state_d = state;
        load    = 1'b0;
        adv     = 1'b0;
        swap    = 1'b0;
        clr     = 1'b1;
        en      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    load    = 1'b1;
                    state_d = S_DWELL;
                end
            end
            S_DWELL: begin
                clr = 1'b0;
                en  = 1'b1;
                if (i_abort) begin
                    clr     = 1'b1;
                    en      = 1'b0;
                    state_d = S_IDLE;
                end else if (tc) begin
                    if (cur == sh_stop) begin
                        if (sh_mode) begin
                            swap = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // shadow config, current code and the new-code strobe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cur      <= F_RST;
            sh_stop  <= '0;
            sh_step  <= '0;
            sh_dwell <= '0;
            sh_up    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (load) begin
                cur      <= i_f_start;
                sh_stop  <= i_f_stop;
                sh_step  <= (i_f_step == '0) ? FW'(1) : i_f_step;
                sh_dwell <= i_dwell;
                sh_up    <= (i_f_start < i_f_stop);
                valid_q  <= 1'b1;
            end else if (adv || swap) begin
                cur     <= nxt;
                valid_q <= (nxt != cur);
                if (swap) begin
                    sh_stop <= lim;
                    sh_up   <= ~sh_up;
                end
            end
        end
    end

endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// tb_sine_sweep_ctrl: scoreboard bench for sine_sweep_ctrl.
// Expected code/done events are queued by a sweep model, popped by a monitor.
module tb_sine_sweep_ctrl;

    localparam int FW = 8;
    localparam int DW = 24;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_mode = 1'b0;
    logic [FW-1:0] i_f_start = '0;
    logic [FW-1:0] i_f_stop = '0;
    logic [FW-1:0] i_f_step = '0;
    logic [DW-1:0] i_dwell = '0;
    logic [FW-1:0] o_sine_f;
    logic          o_f_valid;
    logic          o_busy;
    logic          o_done;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        bit done;
        int code;
        int t;
    } ev_t;

    ev_t exp_q[$];

    sine_sweep_ctrl #(
        .FW(FW),
        .DW(DW),
        .F_RST(8'd50)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (i_start),
        .i_abort  (i_abort),
        .i_f_start(i_f_start),
        .i_f_stop (i_f_stop),
        .i_f_step (i_f_step),
        .i_dwell  (i_dwell),
        .i_mode   (i_mode),
        .o_sine_f (o_sine_f),
        .o_f_valid(o_f_valid),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    always #5 i_clk = ~i_clk;

    // monitor: every new code or done pulse must match the next queued event
    always @(negedge i_clk) begin : mon
        ev_t e;
        cyc++;
        if (o_f_valid || o_done) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: cyc=%0d valid=%0d done=%0d code=%0d, want none",
                         cyc, o_f_valid, o_done, o_sine_f);
            end else begin
                e = exp_q.pop_front();
                if (o_done != e.done || o_f_valid == e.done ||
                    int'(o_sine_f) != e.code || cyc != e.t) begin
                    n_fail++;
                    $display("FAIL event: got done=%0d valid=%0d code=%0d cyc=%0d, want done=%0d code=%0d cyc=%0d",
                             o_done, o_f_valid, o_sine_f, cyc, e.done, e.code, e.t);
                end
            end
        end
        if (o_done) begin
            n_chk++;
            if (o_busy) begin
                n_fail++;
                $display("FAIL busy_at_done: got 1, want 0");
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    function automatic int toward(input int c, input int s, input int tgt);
        if (tgt > c) return (c + s > tgt) ? tgt : c + s;
        return (c - s < tgt) ? tgt : c - s;
    endfunction

    // sweep model: events visible at cycles n0+2, then every dw+1 cycles
    task automatic plan(input int fs, input int fe, input int st, input int dw,
                        input int md, input int n0, input int limit,
                        output int last_code, output int t_end);
        int c, tgt, org, t, s, tmp;
        s = (st == 0) ? 1 : st;
        c = fs;
        tgt = fe;
        org = fs;
        t = n0 + 2;
        last_code = fs;
        t_end = t;
        while (t <= limit) begin
            exp_q.push_back(ev_t'{1'b0, c, t});
            last_code = c;
            t_end = t;
            t += dw + 1;
            if (c == tgt) begin
                if (md == 0) begin
                    if (t <= limit) begin
                        exp_q.push_back(ev_t'{1'b1, c, t});
                        t_end = t;
                    end
                    break;
                end
                tmp = tgt;
                tgt = org;
                org = tmp;
            end
            c = toward(c, s, tgt);
        end
    endtask

    task automatic noise(input bit allow_start);
        i_f_start = FW'($urandom);
        i_f_stop  = FW'($urandom);
        i_f_step  = FW'($urandom);
        i_dwell   = DW'($urandom);
        i_mode    = 1'($urandom);
        i_start   = allow_start && ($urandom_range(0, 3) == 0);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // kind: 0 = run to completion, 1 = abort after cut cycles, 2 = reset
    task automatic run(input int fs, input int fe, input int st, input int dw,
                       input int md, input int kind, input int cut);
        int n0, last_code, t_end, md_eff, limit;
`ifdef SINE_SWEEP_CONT_EN
        md_eff = md;
`else
        md_eff = 0;
`endif
        n0 = cyc;
        if (kind == 0) limit = n0 + 1000000;
        else if (kind == 1) limit = n0 + cut + 1;
        else limit = n0 + cut;
        plan(fs, fe, st, dw, md_eff, n0, limit, last_code, t_end);
        i_f_start = FW'(fs);
        i_f_stop  = FW'(fe);
        i_f_step  = FW'(st);
        i_dwell   = DW'(dw);
        i_mode    = md[0];
        i_start   = 1'b1;
        tick();
        i_start = 1'b0;
        if (kind == 0) begin
            while (cyc < t_end) begin
                noise(1'b1);
                tick();
            end
            i_start = 1'b0;
            check("end_busy", int'(o_busy), 0);
            check("end_code", int'(o_sine_f), fe);
        end else begin
            while (cyc < n0 + cut) begin
                noise(1'b0);
                tick();
            end
            if (kind == 1) begin
                i_abort = 1'b1;
                tick();
                i_abort = 1'b0;
                check("abort_busy", int'(o_busy), 0);
                check("abort_code", int'(o_sine_f), last_code);
                check("abort_done", int'(o_done), 0);
            end else begin
                i_rst_n = 1'b0;
                #1;
                check("rst_code", int'(o_sine_f), 50);
                check("rst_busy", int'(o_busy), 0);
                check("rst_done", int'(o_done), 0);
                check("rst_valid", int'(o_f_valid), 0);
                tick();
                tick();
                i_rst_n = 1'b1;
            end
        end
        tick();
        tick();
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int fs, fe, st, dw, md, kind, cut;
        repeat (3) tick();
        check("reset_code", int'(o_sine_f), 50);
        check("reset_valid", int'(o_f_valid), 0);
        check("reset_busy", int'(o_busy), 0);
        check("reset_done", int'(o_done), 0);
        i_rst_n = 1'b1;
        tick();
        check("idle_code", int'(o_sine_f), 50);
        check("idle_busy", int'(o_busy), 0);

        run(10, 14, 2, 3, 0, 0, 0);
        run(200, 190, 4, 0, 0, 0, 0);
        run(3, 5, 0, 2, 0, 0, 0);
        run(250, 255, 10, 0, 0, 0, 0);
        run(5, 0, 10, 1, 0, 0, 0);
        run(77, 77, 3, 2, 0, 0, 0);
`ifdef SINE_SWEEP_CONT_EN
        run(5, 7, 1, 1, 1, 1, 11);
`else
        run(5, 7, 1, 1, 1, 0, 0);
`endif
        run(20, 60, 5, 2, 0, 1, 9);
        run(20, 60, 5, 2, 0, 2, 7);

        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        repeat (3) tick();
        check("start_abort_busy", int'(o_busy), 0);
        check("start_abort_code", int'(o_sine_f), 50);

        for (int i = 0; i < 24; i++) begin
            fs = $urandom_range(0, 255);
            fe = $urandom_range(0, 255);
            st = $urandom_range(0, 48);
            dw = $urandom_range(0, 3);
            md = $urandom_range(0, 1);
            kind = $urandom_range(0, 2);
            cut = $urandom_range(1, 40);
`ifdef SINE_SWEEP_CONT_EN
            if (md == 1) begin
                if (fe == fs) fe = (fs + 1) % 256;
                kind = 1;
                cut = $urandom_range(3, 80);
            end
`endif
            if (kind == 0) cut = 0;
            run(fs, fe, st, dw, md, kind, cut);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
